// File: rtl/usbf_wb_mst.sv
// WISHBONE initiator for the USB function core: turns a command/response request into
// single-beat STB/CYC pulses, each followed by an idle gap, with per-beat ACK timeout.
module usbf_wb_mst #(
    parameter int unsigned AW      = 18,
    parameter int unsigned TO_CYC  = 64,
    parameter int unsigned GAP_CYC = 4
) (
    input  logic          wb_clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_adr,
    input  logic [3:0]    cmd_len,
    input  logic [31:0]   wdata,
    output logic          wdata_ack,
    output logic          rsp_valid,
    output logic [31:0]   rsp_data,
    output logic          rsp_last,
    output logic          rsp_err,
    output logic          busy,
    output logic [AW-1:0] wb_addr_o,
    output logic [31:0]   wb_data_o,
    input  logic [31:0]   wb_data_i,
    output logic          wb_we_o,
    output logic          wb_stb_o,
    output logic          wb_cyc_o,
    input  logic          wb_ack_i
);

    localparam int unsigned TO_W  = $clog2(TO_CYC);
    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_start;
    logic              w_next;
    logic              w_ack;
    logic              w_to;
    logic              w_gap_end;
    logic              w_beat_we;
    logic [AW-1:0]     w_adr_aligned;

    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_we;
    logic [3:0]        r_beats;
    logic [AW-1:0]     r_addr;
    logic [31:0]       r_wdata;
    logic              r_wdata_ack;
    logic              r_stb;
    logic [TO_W-1:0]   r_to_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_data;
    logic              r_rsp_last;
    logic              r_rsp_err;

    assign w_adr_aligned = cmd_adr & ~AW'(3);
    assign w_beat_we     = w_start ? cmd_we : r_we;

    always_ff @(posedge wb_clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state plus one-cycle event strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_next      = 1'b0;
        w_ack       = 1'b0;
        w_to        = 1'b0;
        w_gap_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // ACK wins over a timeout firing in the same cycle.
                if (wb_ack_i) begin
                    w_ack       = 1'b1;
                    w_state_nxt = S_GAP;
                end else if (r_to_cnt == TO_W'(TO_CYC - 1)) begin
                    w_to        = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                    w_gap_end = 1'b1;
                    if (r_beats != 4'd0) begin
                        w_next      = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge rst) begin
        if (rst) begin
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_we        <= 1'b0;
            r_beats     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wdata_ack <= 1'b0;
            r_stb       <= 1'b0;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_wdata_ack <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;

            if (w_start) begin
                r_we    <= cmd_we;
                r_beats <= cmd_len;
                r_addr  <= w_adr_aligned;
            end
            if (w_next) begin
                r_beats <= r_beats - 4'd1;
                r_addr  <= r_addr + AW'(4);
            end
            // Beat start: raise STB, restart timeout, take one write word.
            if (w_start || w_next) begin
                r_stb    <= 1'b1;
                r_to_cnt <= '0;
                if (w_beat_we) begin
                    r_wdata     <= wdata;
                    r_wdata_ack <= 1'b1;
                end
            end

            if (r_state == S_REQ && !w_ack && !w_to)
                r_to_cnt <= r_to_cnt + TO_W'(1);

            if (w_ack) begin
                r_stb     <= 1'b0;
                r_gap_cnt <= '0;
                if (!r_we) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= wb_data_i;
                    r_rsp_last  <= (r_beats == 4'd0);
                end else if (r_beats == 4'd0) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_last  <= 1'b1;
                end
            end

            // Timeout aborts the command: remaining beats are dropped.
            if (w_to) begin
                r_stb       <= 1'b0;
                r_gap_cnt   <= '0;
                r_beats     <= '0;
                r_rsp_valid <= 1'b1;
                r_rsp_last  <= 1'b1;
                r_rsp_err   <= 1'b1;
            end

            if (r_state == S_GAP && !w_gap_end)
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign wdata_ack = r_wdata_ack;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_last  = r_rsp_last;
    assign rsp_err   = r_rsp_err;
    assign wb_addr_o = r_addr;
    assign wb_data_o = r_wdata;
    assign wb_we_o   = r_we;
    assign wb_stb_o  = r_stb;
    assign wb_cyc_o  = r_stb;

endmodule

// File: tb/tb_usbf_wb_mst.sv
// Bench for usbf_wb_mst: directed table, reset-abort sequence and randomized commands
// checked against a per-beat reference model and a behavioural WISHBONE slave.
module tb_usbf_wb_mst;

    localparam int unsigned AW  = 18;
    localparam int          TO  = 64;
    localparam int          GAP = 4;

    logic          wb_clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [3:0]    cmd_len;
    logic [31:0]   wdata;
    logic          wdata_ack;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic          rsp_last;
    logic          rsp_err;
    logic          busy;
    logic [AW-1:0] wb_addr_o;
    logic [31:0]   wb_data_o;
    logic [31:0]   wb_data_i;
    logic          wb_we_o;
    logic          wb_stb_o;
    logic          wb_cyc_o;
    logic          wb_ack_i;

    usbf_wb_mst #(.AW(AW), .TO_CYC(TO), .GAP_CYC(GAP)) dut (
        .wb_clk(wb_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_len(cmd_len), .wdata(wdata),
        .wdata_ack(wdata_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy), .wb_addr_o(wb_addr_o),
        .wb_data_o(wb_data_o), .wb_data_i(wb_data_i), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
    );

    always #5 wb_clk = ~wb_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Slave: word memory, per-beat ACK latency (0 = never ACK), optional stray ACKs.
    logic [31:0] slv_mem [0:65535];
    int          lat_q [16];
    bit          stray = 1'b0;
    int          s_cnt = 0;
    int          s_beat = 0;

    always @(negedge wb_clk) begin
        if (wb_stb_o) begin
            s_cnt++;
            if (s_beat < 16 && s_cnt == lat_q[s_beat[3:0]]) begin
                wb_ack_i  = 1'b1;
                wb_data_i = slv_mem[wb_addr_o[AW-1:2]];
            end else begin
                wb_ack_i  = 1'b0;
                wb_data_i = $urandom;
            end
        end else begin
            if (s_cnt != 0) s_beat++;
            if (cmd_ready) s_beat = 0;
            s_cnt     = 0;
            wb_ack_i  = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            wb_data_i = $urandom;
        end
    end

    // Issue one command, observe it to completion, compare against the model.
    task automatic run_cmd(input logic we_i, input logic [AW-1:0] adr_i, input logic [3:0] len_i,
                           output int o_beats, output int o_rsps, output logic o_err,
                           output logic [AW-1:0] o_last_addr, output int o_hi,
                           output logic [31:0] o_data);
        logic [31:0]   words [16];
        logic [AW-1:0] a_obs [16];
        logic [31:0]   wd_obs [16];
        int            hi_obs [16];
        int            gap_obs [16];
        logic [33:0]   rq [$];
        logic [33:0]   eq [$];
        int nb = 0, nw = 0, cyc = 0, lowrun = 0, final_gap = -1, e_beats = 0;
        bit prev_stb = 0, done = 0, first_ok = 0, bad_cyc = 0, bad_busy = 0, bad_we = 0, tmo = 0;
        logic [AW-1:0] ea;
        for (int i = 0; i < 16; i++) begin
            words[i] = $urandom; hi_obs[i] = 0; gap_obs[i] = -1; a_obs[i] = '0; wd_obs[i] = '0;
        end
        wdata     = words[0];
        cmd_we    = we_i;
        cmd_adr   = adr_i;
        cmd_len   = len_i;
        cmd_valid = 1'b1;
        while (!done && cyc < 3000) begin
            @(negedge wb_clk);
            cyc++;
            if (cyc == 1) first_ok = wb_stb_o;
            if (wb_cyc_o !== wb_stb_o) bad_cyc = 1;
            if (busy === cmd_ready) bad_busy = 1;
            if (cmd_ready) begin
                final_gap = lowrun;
                done      = 1;
                cmd_valid = 1'b0;
            end else begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_adr   = AW'($urandom);
                cmd_we    = 1'($urandom_range(0, 1));
                if (wb_stb_o) begin
                    if (!prev_stb) begin
                        if (nb > 0 && nb < 17) gap_obs[nb-1] = lowrun;
                        if (nb < 16) begin a_obs[nb] = wb_addr_o; wd_obs[nb] = wb_data_o; end
                        nb++;
                    end
                    if (nb <= 16) hi_obs[nb-1]++;
                    if (wb_we_o !== we_i) bad_we = 1;
                end else begin
                    lowrun = prev_stb ? 1 : lowrun + 1;
                end
            end
            if (wdata_ack) begin nw++; if (nw < 16) wdata = words[nw]; end
            if (rsp_valid) rq.push_back({rsp_data, rsp_last, rsp_err});
            prev_stb = wb_stb_o;
        end
        cmd_valid = 1'b0;
        chk("cmd_completes", 64'(done), 64'd1);

        // Model: beats run in order until one is never ACKed within TO cycles.
        for (int i = 0; i <= int'(len_i); i++) begin
            e_beats++;
            ea = AW'(((int'(adr_i) / 4) * 4 + 4 * i) % (1 << AW));
            if (lat_q[i] == 0 || lat_q[i] > TO) begin
                tmo = 1; eq.push_back({32'h0, 1'b1, 1'b1}); break;
            end
            if (!we_i)                 eq.push_back({slv_mem[ea[AW-1:2]], 1'(i == int'(len_i)), 1'b0});
            else if (i == int'(len_i)) eq.push_back({32'h0, 1'b1, 1'b0});
        end
        chk("beat_count", 64'(nb), 64'(e_beats));
        chk("stb_latency", 64'(first_ok), 64'd1);
        for (int i = 0; i < e_beats && i < nb; i++) begin
            ea = AW'(((int'(adr_i) / 4) * 4 + 4 * i) % (1 << AW));
            chk("beat_addr", 64'(a_obs[i]), 64'(ea));
            chk("stb_high_cycles", 64'(hi_obs[i]),
                64'((lat_q[i] >= 1 && lat_q[i] <= TO) ? lat_q[i] : TO));
            if (we_i) chk("beat_wdata", 64'(wd_obs[i]), 64'(words[i]));
            if (i > 0) chk("gap_cycles", 64'(gap_obs[i-1]), 64'(GAP));
        end
        chk("final_gap", 64'(final_gap), 64'(GAP));
        chk("wdata_ack_count", 64'(nw), 64'(we_i ? e_beats : 0));
        chk("rsp_count", 64'(rq.size()), 64'(eq.size()));
        for (int i = 0; i < eq.size() && i < rq.size(); i++)
            chk("rsp_data_last_err", 64'(rq[i]), 64'(eq[i]));
        chk("cyc_eq_stb", 64'(bad_cyc), 64'd0);
        chk("busy_vs_ready", 64'(bad_busy), 64'd0);
        chk("we_stable", 64'(bad_we), 64'd0);
        if (tmo) chk("timeout_seen", 64'(rq.size() > 0 ? rq[rq.size()-1][0] : 1'b0), 64'd1);

        o_beats     = nb;
        o_rsps      = rq.size();
        o_err       = (rq.size() > 0) ? rq[rq.size()-1][0] : 1'b0;
        o_data      = (rq.size() > 0) ? rq[rq.size()-1][33:2] : 32'h0;
        o_last_addr = (nb > 0 && nb <= 16) ? a_obs[nb-1] : '0;
        o_hi        = 0;
        for (int i = 0; i < 16; i++) o_hi += hi_obs[i];
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [3:0]    len;
        int            lat;
        int            e_beats;
        int            e_rsps;
        logic          e_err;
        logic [AW-1:0] e_last_addr;
        int            e_hi;
        logic [31:0]   e_data;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int            r_beats, r_rsps, r_hi, n_rise, guard;
        logic          r_err, saw_rsp;
        logic [AW-1:0] r_addr;
        logic [31:0]   r_data;

        for (int i = 0; i < 65536; i++) slv_mem[i] = $urandom;
        slv_mem[18'h040 >> 2] = 32'hDEADBEEF;
        slv_mem[18'h400 >> 2] = 32'h12345678;
        slv_mem[0]            = 32'hCAFEF00D;
        slv_mem[18'h500 >> 2] = 32'h0BADC0DE;

        tbl[0] = '{1'b0, 18'h00040, 4'd0, 5,  1, 1, 1'b0, 18'h00040, 5,  32'hDEADBEEF};
        tbl[1] = '{1'b1, 18'h00100, 4'd3, 2,  4, 1, 1'b0, 18'h0010C, 8,  32'h0};
        tbl[2] = '{1'b0, 18'h00200, 4'd0, 0,  1, 1, 1'b1, 18'h00200, 64, 32'h0};
        tbl[3] = '{1'b0, 18'h00300, 4'd3, 0,  1, 1, 1'b1, 18'h00300, 64, 32'h0};
        tbl[4] = '{1'b0, 18'h00400, 4'd0, 64, 1, 1, 1'b0, 18'h00400, 64, 32'h12345678};
        tbl[5] = '{1'b0, 18'h3FFFC, 4'd1, 3,  2, 2, 1'b0, 18'h00000, 6,  32'hCAFEF00D};
        tbl[6] = '{1'b0, 18'h00503, 4'd0, 1,  1, 1, 1'b0, 18'h00500, 1,  32'h0BADC0DE};
        tbl[7] = '{1'b1, 18'h00600, 4'd0, 65, 1, 1, 1'b1, 18'h00600, 64, 32'h0};
        tbl[8] = '{1'b1, 18'h3FFF8, 4'd2, 1,  3, 1, 1'b0, 18'h00000, 3,  32'h0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0; wdata = '0;
        for (int i = 0; i < 16; i++) lat_q[i] = 1;
        repeat (3) @(negedge wb_clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_stb",       64'(wb_stb_o),  64'd0);
        chk("rst_cyc",       64'(wb_cyc_o),  64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_wdata_ack", 64'(wdata_ack), 64'd0);
        chk("rst_addr",      64'(wb_addr_o), 64'd0);
        chk("rst_we",        64'(wb_we_o),   64'd0);
        rst = 1'b0;
        @(negedge wb_clk);

        for (int t = 0; t < 9; t++) begin
            for (int i = 0; i < 16; i++) lat_q[i] = tbl[t].lat;
            stray = 1'b0;
            run_cmd(tbl[t].we, tbl[t].adr, tbl[t].len, r_beats, r_rsps, r_err, r_addr, r_hi, r_data);
            chk($sformatf("tbl%0d_beats", t),     64'(r_beats), 64'(tbl[t].e_beats));
            chk($sformatf("tbl%0d_rsps", t),      64'(r_rsps),  64'(tbl[t].e_rsps));
            chk($sformatf("tbl%0d_err", t),       64'(r_err),   64'(tbl[t].e_err));
            chk($sformatf("tbl%0d_last_addr", t), 64'(r_addr),  64'(tbl[t].e_last_addr));
            chk($sformatf("tbl%0d_stb_hi", t),    64'(r_hi),    64'(tbl[t].e_hi));
            chk($sformatf("tbl%0d_data", t),      64'(r_data),  64'(tbl[t].e_data));
        end

        // Reset during beat 2 of a 4-beat write abandons the command silently.
        for (int i = 0; i < 16; i++) lat_q[i] = 2;
        wdata = 32'h11111111; cmd_we = 1'b1; cmd_adr = 18'h00100; cmd_len = 4'd3; cmd_valid = 1'b1;
        n_rise = 0; guard = 0;
        while (n_rise < 2 && guard < 200) begin
            @(negedge wb_clk);
            guard++;
            cmd_valid = 1'b0;
            if (wdata_ack) begin
                n_rise++;
                wdata = 32'h22222222;
            end
        end
        chk("rst_mid_reached_beat2", 64'(n_rise), 64'd2);
        chk("rst_mid_stb_before", 64'(wb_stb_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_stb",       64'(wb_stb_o),  64'd0);
        chk("rst_mid_cyc",       64'(wb_cyc_o),  64'd0);
        chk("rst_mid_wdata_ack", 64'(wdata_ack), 64'd0);
        chk("rst_mid_ready",     64'(cmd_ready), 64'd1);
        saw_rsp = 1'b0;
        repeat (3) begin
            @(negedge wb_clk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge wb_clk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        chk("rst_mid_no_rsp",     64'(saw_rsp),   64'd0);
        chk("rst_mid_ready_post", 64'(cmd_ready), 64'd1);
        chk("rst_mid_busy_post",  64'(busy),      64'd0);
        run_cmd(1'b1, 18'h00800, 4'd1, r_beats, r_rsps, r_err, r_addr, r_hi, r_data);
        chk("post_rst_beats", 64'(r_beats), 64'd2);

        // Randomized commands, latencies occasionally at or beyond the timeout.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 19))
                    0:       lat_q[i] = 0;
                    1:       lat_q[i] = TO;
                    2:       lat_q[i] = TO + 1;
                    default: lat_q[i] = $urandom_range(1, 6);
                endcase
            end
            stray = 1'($urandom_range(0, 1));
            run_cmd(1'($urandom_range(0, 1)), AW'($urandom), 4'($urandom_range(0, 15)),
                    r_beats, r_rsps, r_err, r_addr, r_hi, r_data);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
